// File: rtl/control_unit_if.sv
// Control bundle between the hardwired sequencer (master) and the CPU datapath / IR side (slave).
// Carries the IR, CON, stop and run handshake signals, the ALU select and every datapath strobe.
interface control_unit_if;
  logic [31:0] ir;
  logic        con;
  logic        stop;
  logic        run;
  logic [4:0]  opcode;
  logic        Read, Write, IncPC;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, InPortin, CONin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, InPortout, Cout;

  modport master (
    input  ir, con, stop,
    output run, opcode, Read, Write, IncPC,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, InPortin, CONin,
    output HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, InPortout, Cout
  );

  modport slave (
    output ir, con, stop,
    input  run, opcode, Read, Write, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, InPortin, CONin,
    input  HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, InPortout, Cout
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer: strobes are a combinational decode of step, IR opcode and CON.
// 3 to 8 cycles per instruction; no backpressure, stop is honoured only at an instruction boundary.
module control_unit (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_IMM, C_UNARY, C_LDI, C_LD, C_ST, C_MULDIV,
    C_BR, C_JR, C_IN, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  state_t     state_q, state_d;
  logic       run_q, run_d;
  iclass_t    iclass;
  state_t     last_step;
  logic [4:0] alu_sel;
  logic [4:0] op;

  assign op = cu.ir[31:27];

  always_comb begin
    iclass  = C_NOP;
    alu_sel = 5'b00000;
    case (op)
      5'd0:  begin iclass = C_LD;  alu_sel = 5'b00011; end
      5'd1:  begin iclass = C_LDI; alu_sel = 5'b00011; end
      5'd2:  begin iclass = C_ST;  alu_sel = 5'b00011; end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             begin iclass = C_RTYPE; alu_sel = op; end
      5'd12: begin iclass = C_IMM; alu_sel = 5'b00011; end
      5'd13: begin iclass = C_IMM; alu_sel = 5'b00101; end
      5'd14: begin iclass = C_IMM; alu_sel = 5'b00110; end
      5'd15, 5'd16: begin iclass = C_MULDIV; alu_sel = op; end
      5'd17, 5'd18: begin iclass = C_UNARY;  alu_sel = op; end
      5'd19: begin iclass = C_BR;  alu_sel = 5'b00011; end
      5'd20: iclass = C_JR;
      5'd22: iclass = C_IN;
      5'd24: iclass = C_MFHI;
      5'd25: iclass = C_MFLO;
      5'd27: iclass = C_HALT;
      default: iclass = C_NOP;
    endcase
  end

  always_comb begin
    last_step = S_T2;
    case (iclass)
      C_JR, C_IN, C_MFHI, C_MFLO: last_step = S_T3;
      C_UNARY:                    last_step = S_T4;
      C_RTYPE, C_IMM, C_LDI:      last_step = S_T5;
      C_MULDIV, C_BR:             last_step = S_T6;
      C_LD, C_ST:                 last_step = S_T7;
      default:                    last_step = S_T2;
    endcase
  end

  // The first edge after clear only arms run; the step counter holds at T0 for that edge.
  always_comb begin
    state_d = state_q;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (!run_q) begin
      state_d = S_T0;
    end else if (state_q == last_step) begin
      state_d = (iclass == C_HALT || cu.stop) ? S_HALT : S_T0;
    end else begin
      state_d = state_t'(state_q + 4'd1);
    end
    run_d = (state_d != S_HALT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_T0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign cu.run = run_q;

  always_comb begin
    cu.opcode = 5'b00000;
    cu.Read = 1'b0; cu.Write = 1'b0; cu.IncPC = 1'b0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0; cu.Rin = 1'b0; cu.Rout = 1'b0; cu.BAout = 1'b0;
    cu.HIin = 1'b0; cu.LOin = 1'b0; cu.Yin = 1'b0; cu.Zin = 1'b0; cu.PCin = 1'b0;
    cu.IRin = 1'b0; cu.MARin = 1'b0; cu.MDRin = 1'b0; cu.InPortin = 1'b0; cu.CONin = 1'b0;
    cu.HIout = 1'b0; cu.LOout = 1'b0; cu.Yout = 1'b0; cu.Zhighout = 1'b0; cu.Zlowout = 1'b0;
    cu.PCout = 1'b0; cu.MARout = 1'b0; cu.MDRout = 1'b0; cu.InPortout = 1'b0; cu.Cout = 1'b0;
    if (run_q) begin
      if (state_q >= S_T3 && state_q <= S_T7) cu.opcode = alu_sel;
      case (state_q)
        S_T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1; end
        S_T1: begin cu.Zlowout = 1'b1; cu.PCin = 1'b1; cu.Read = 1'b1; cu.MDRin = 1'b1; end
        S_T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
        S_T3: case (iclass)
          C_RTYPE, C_IMM:    begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          C_UNARY:           begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; end
          C_LDI, C_LD, C_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
          C_MULDIV:          begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          C_BR:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          C_JR:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          C_IN:              begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_MFHI:            begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_MFLO:            begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          default: ;
        endcase
        S_T4: case (iclass)
          C_RTYPE:                  begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          C_UNARY:                  begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_MULDIV:                 begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; end
          C_BR:                     begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
          default: ;
        endcase
        S_T5: case (iclass)
          C_RTYPE, C_IMM, C_LDI: begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_LD, C_ST:            begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
          C_MULDIV:              begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
          C_BR:                  begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          default: ;
        endcase
        S_T6: case (iclass)
          C_LD:     begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
          C_ST:     begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
          C_MULDIV: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
          C_BR:     begin cu.Zlowout = cu.con; cu.PCin = cu.con; end
          default: ;
        endcase
        S_T7: case (iclass)
          C_LD:    begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_ST:    cu.Write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a per-instruction microstep list built from the opcode map is
// compared cycle by cycle against the strobes, ALU select and run flag.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear;
  control_unit_if cu();

  control_unit dut (.clock(clock), .clear(clear), .cu(cu));

  always #5 clock = ~clock;

  localparam logic [28:0] M_Read = 29'd1 << 28, M_Write = 29'd1 << 27, M_IncPC = 29'd1 << 26;
  localparam logic [28:0] M_Gra = 29'd1 << 25, M_Grb = 29'd1 << 24, M_Grc = 29'd1 << 23;
  localparam logic [28:0] M_Rin = 29'd1 << 22, M_Rout = 29'd1 << 21, M_BAout = 29'd1 << 20;
  localparam logic [28:0] M_HIin = 29'd1 << 19, M_LOin = 29'd1 << 18, M_Yin = 29'd1 << 17;
  localparam logic [28:0] M_Zin = 29'd1 << 16, M_PCin = 29'd1 << 15, M_IRin = 29'd1 << 14;
  localparam logic [28:0] M_MARin = 29'd1 << 13, M_MDRin = 29'd1 << 12, M_InPortin = 29'd1 << 11;
  localparam logic [28:0] M_CONin = 29'd1 << 10, M_HIout = 29'd1 << 9, M_LOout = 29'd1 << 8;
  localparam logic [28:0] M_Yout = 29'd1 << 7, M_Zhighout = 29'd1 << 6, M_Zlowout = 29'd1 << 5;
  localparam logic [28:0] M_PCout = 29'd1 << 4, M_MARout = 29'd1 << 3, M_MDRout = 29'd1 << 2;
  localparam logic [28:0] M_InPortout = 29'd1 << 1, M_Cout = 29'd1 << 0;
  localparam logic [28:0] F0 = M_PCout | M_MARin | M_IncPC | M_Zin;
  localparam logic [28:0] F1 = M_Zlowout | M_PCin | M_Read | M_MDRin;
  localparam logic [28:0] F2 = M_MDRout | M_IRin;

  wire [28:0] strobes = {cu.Read, cu.Write, cu.IncPC, cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout,
                         cu.BAout, cu.HIin, cu.LOin, cu.Yin, cu.Zin, cu.PCin, cu.IRin, cu.MARin,
                         cu.MDRin, cu.InPortin, cu.CONin, cu.HIout, cu.LOout, cu.Yout, cu.Zhighout,
                         cu.Zlowout, cu.PCout, cu.MARout, cu.MDRout, cu.InPortout, cu.Cout};

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_s[$];
  logic [4:0]  exp_op[$];
  logic [28:0] got_s[$];
  logic [4:0]  got_op[$];
  logic        got_run[$];
  logic [34:0] got_h[$];

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    if ((op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18)) return op;
    if (op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'd12 || op == 5'd19) return 5'd3;
    if (op == 5'd13) return 5'd5;
    if (op == 5'd14) return 5'd6;
    return 5'd0;
  endfunction

  // Expected step list for one instruction: fetch, then the execute microsteps of its opcode.
  task automatic model(input logic [31:0] irv, input logic conv);
    logic [28:0] ex[$];
    logic [4:0]  op;
    logic [28:0] a3, a4, a5;
    op = irv[31:27];
    a3 = M_Grb | M_BAout | M_Yin;
    a4 = M_Cout | M_Zin;
    a5 = M_Zlowout | M_MARin;
    exp_s.delete(); exp_op.delete();
    exp_s.push_back(F0); exp_s.push_back(F1); exp_s.push_back(F2);
    repeat (3) exp_op.push_back(5'd0);
    if (op >= 5'd3 && op <= 5'd11) begin
      ex.push_back(M_Grb | M_Rout | M_Yin); ex.push_back(M_Grc | M_Rout | M_Zin);
      ex.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      ex.push_back(M_Grb | M_Rout | M_Yin); ex.push_back(a4); ex.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op == 5'd17 || op == 5'd18) begin
      ex.push_back(M_Grb | M_Rout | M_Zin); ex.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op == 5'd1) begin
      ex.push_back(a3); ex.push_back(a4); ex.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op == 5'd0) begin
      ex.push_back(a3); ex.push_back(a4); ex.push_back(a5);
      ex.push_back(M_Read | M_MDRin); ex.push_back(M_MDRout | M_Gra | M_Rin);
    end else if (op == 5'd2) begin
      ex.push_back(a3); ex.push_back(a4); ex.push_back(a5);
      ex.push_back(M_Gra | M_Rout | M_MDRin); ex.push_back(M_Write);
    end else if (op == 5'd15 || op == 5'd16) begin
      ex.push_back(M_Gra | M_Rout | M_Yin); ex.push_back(M_Grb | M_Rout | M_Zin);
      ex.push_back(M_Zlowout | M_LOin); ex.push_back(M_Zhighout | M_HIin);
    end else if (op == 5'd19) begin
      ex.push_back(M_Gra | M_Rout | M_CONin); ex.push_back(M_PCout | M_Yin); ex.push_back(a4);
      ex.push_back(conv ? (M_Zlowout | M_PCin) : 29'd0);
    end else if (op == 5'd20) ex.push_back(M_Gra | M_Rout | M_PCin);
    else if (op == 5'd22) ex.push_back(M_InPortout | M_Gra | M_Rin);
    else if (op == 5'd24) ex.push_back(M_HIout | M_Gra | M_Rin);
    else if (op == 5'd25) ex.push_back(M_LOout | M_Gra | M_Rin);
    foreach (ex[i]) begin
      exp_s.push_back(ex[i]);
      exp_op.push_back(alu_of(op));
    end
  endtask

  // Starts just after the edge that enters T0; con/stop are noise except in br T6 and on the final edge.
  task automatic run_instr(input logic [31:0] irv, input logic conv, input logic stopv, input logic halts);
    int n;
    n = exp_s.size();
    got_s.delete(); got_op.delete(); got_run.delete(); got_h.delete();
    cu.ir = irv;
    cu.con = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      got_s.push_back(strobes); got_op.push_back(cu.opcode); got_run.push_back(cu.run);
      cu.con  = (k == 5) ? conv : 1'($urandom);
      cu.stop = (k == n - 1) ? stopv : 1'($urandom);
    end
    @(posedge clock); #1;
    cu.stop = 1'b0; cu.con = 1'b0;
    if (halts) begin
      repeat (20) begin
        @(negedge clock);
        got_h.push_back({cu.run, cu.opcode, strobes});
      end
    end
  endtask

  task automatic do_reset();
    cu.stop = 1'b0;
    clear = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; cu.ir = 32'h18918000; cu.con = 1'b0; cu.stop = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({cu.run, cu.opcode, strobes} !== 35'd0) begin
      errors++; $display("FAIL reset_hold: got run=%b op=%b strobes=%h, want all 0", cu.run, cu.opcode, strobes);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (strobes !== F0 || cu.run !== 1'b1) begin
      errors++; $display("FAIL reset_release: got strobes=%h run=%b, want %h run=1", strobes, cu.run, F0);
    end
    model(32'h18918000, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if (strobes !== exp_s[k] || cu.opcode !== exp_op[k] || cu.run !== 1'b1) begin
        errors++; $display("FAIL reset_pre step %0d: got %h/%b/%b want %h/%b/1", k, strobes, cu.opcode, cu.run, exp_s[k], exp_op[k]);
      end
    end
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({cu.run, cu.opcode, strobes} !== 35'd0) begin
      errors++; $display("FAIL reset_abort: got run=%b op=%b strobes=%h, want all 0", cu.run, cu.opcode, strobes);
    end
    @(posedge clock); #1;
    checks++;
    if ({cu.run, cu.opcode, strobes} !== 35'd0) begin
      errors++; $display("FAIL reset_held_edge: got run=%b op=%b strobes=%h, want all 0", cu.run, cu.opcode, strobes);
    end
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (strobes !== F0 || cu.run !== 1'b1) begin
      errors++; $display("FAIL reset_restart: got strobes=%h run=%b, want %h run=1", strobes, cu.run, F0);
    end
  endtask

  task automatic test_add();
    model(32'h18918000, 1'b0);
    run_instr(32'h18918000, 1'b0, 1'b0, 1'b0);
    foreach (exp_s[k]) begin
      checks++;
      if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
        errors++; $display("FAIL add step %0d: got %h/%b/%b want %h/%b/1", k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
      end
    end
    checks++;
    if (strobes !== F0 || cu.run !== 1'b1) begin
      errors++; $display("FAIL add_next_t0: got strobes=%h run=%b, want %h run=1", strobes, cu.run, F0);
    end
  endtask

  task automatic test_ld_st();
    logic [31:0] prog [2];
    prog[0] = 32'h00800055; prog[1] = 32'h10800055;
    foreach (prog[p]) begin
      model(prog[p], 1'b0);
      run_instr(prog[p], 1'b0, 1'b0, 1'b0);
      foreach (exp_s[k]) begin
        checks++;
        if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
          errors++; $display("FAIL ldst %h step %0d: got %h/%b/%b want %h/%b/1", prog[p], k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
        end
      end
    end
  endtask

  task automatic test_br();
    for (int c = 0; c < 2; c++) begin
      model(32'h99000005, 1'(c));
      run_instr(32'h99000005, 1'(c), 1'b0, 1'b0);
      foreach (exp_s[k]) begin
        checks++;
        if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
          errors++; $display("FAIL br con=%0d step %0d: got %h/%b/%b want %h/%b/1", c, k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
        end
      end
    end
  endtask

  task automatic test_mul();
    model(32'h79A00000, 1'b0);
    run_instr(32'h79A00000, 1'b0, 1'b0, 1'b0);
    foreach (exp_s[k]) begin
      checks++;
      if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
        errors++; $display("FAIL mul step %0d: got %h/%b/%b want %h/%b/1", k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
      end
    end
  endtask

  task automatic test_stop();
    model(32'h18918000, 1'b0);
    run_instr(32'h18918000, 1'b0, 1'b1, 1'b1);
    foreach (exp_s[k]) begin
      checks++;
      if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
        errors++; $display("FAIL stop_add step %0d: got %h/%b/%b want %h/%b/1", k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
      end
    end
    foreach (got_h[k]) begin
      checks++;
      if (got_h[k] !== 35'd0) begin
        errors++; $display("FAIL stop_halted cycle %0d: got run/op/strobes=%h, want 0", k, got_h[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] irv;
    logic        conv;
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      irv = {op, 27'($urandom)};
      conv = 1'($urandom);
      model(irv, conv);
      run_instr(irv, conv, 1'b0, 1'b0);
      foreach (exp_s[k]) begin
        checks++;
        if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
          errors++; $display("FAIL rand ir=%h step %0d: got %h/%b/%b want %h/%b/1", irv, k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
        end
      end
    end
  endtask

  task automatic test_halt();
    model(32'hD8000000, 1'b0);
    run_instr(32'hD8000000, 1'b0, 1'b0, 1'b1);
    foreach (exp_s[k]) begin
      checks++;
      if (got_s[k] !== exp_s[k] || got_op[k] !== exp_op[k] || got_run[k] !== 1'b1) begin
        errors++; $display("FAIL halt step %0d: got %h/%b/%b want %h/%b/1", k, got_s[k], got_op[k], got_run[k], exp_s[k], exp_op[k]);
      end
    end
    foreach (got_h[k]) begin
      checks++;
      if (got_h[k] !== 35'd0) begin
        errors++; $display("FAIL halt_idle cycle %0d: got run/op/strobes=%h, want 0", k, got_h[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_ld_st();
    test_br();
    test_mul();
    test_stop();
    test_random();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
